fft_stream_adapter: RTL

- Streaming front/back end for the parallel N-point DFT/IDFT cores.
- Collects N serial complex samples over a valid/ready input and issues them to an external core through a next pulse and a parallel frame.
- Captures the core's parallel result after next_out and replays it serially with backpressure.
- Adds a per-frame inverse mode by conjugating input and output, with optional 1/N scaling, so a forward-only core can serve both directions.
- Includes a sticky timeout error.

---
 rtl/fft_stream_pkg.sv | 27 ++
 rtl/fft_stream_adapter_conj.sv | 31 +++
 rtl/fft_stream_adapter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fft_stream_pkg.sv
// Shared types and helpers for the FFT streaming adapter.
package fft_stream_pkg;

    localparam int CPLX_W = 16;
    // Working width of sat_neg; component widths up to NEG_W-1 bits are supported.
    localparam int NEG_W  = 32;

    typedef struct packed {
        logic signed [CPLX_W-1:0] r;
        logic signed [CPLX_W-1:0] i;
    } cplx_t;

    typedef enum logic [2:0] {FILL, ISSUE, FEED, WAIT, CAPTURE, DRAIN} state_t;

    // Two's complement negate of a w-bit value (sign-extended into NEG_W bits);
    // the most negative w-bit value maps to the most positive instead of wrapping.
    function automatic logic signed [NEG_W-1:0] sat_neg(input logic signed [NEG_W-1:0] v,
                                                        input int w);
        logic signed [NEG_W-1:0] one;
        logic signed [NEG_W-1:0] lim;
        one = 1;
        lim = (one <<< (w - 1)) - one;
        if (v < -lim) return lim;
        return -v;
    endfunction

endpackage

// File: rtl/fft_stream_adapter_conj.sv
// Combinational conjugate with saturation and optional arithmetic down-shift.
module cplx_conj_scale
    import fft_stream_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SHIFT  = 3
) (
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic                     conj,
    input  logic                     scale,
    output logic signed [DATA_W-1:0] y_re,
    output logic signed [DATA_W-1:0] y_im
);

    logic signed [NEG_W-1:0]  neg_wide;
    logic signed [DATA_W-1:0] im_c;
    logic                     unused_hi;

    // Upper bits of the widened negate only carry sign extension.
    assign unused_hi = ^neg_wide[NEG_W-1:DATA_W];

    // Negate imag first, then shift both parts when scaling.
    always_comb begin
        neg_wide = sat_neg(NEG_W'(a_im), DATA_W);
        im_c     = conj ? neg_wide[DATA_W-1:0] : a_im;
        y_re     = scale ? (a_re >>> SHIFT) : a_re;
        y_im     = scale ? (im_c >>> SHIFT) : im_c;
    end

endmodule

// File: rtl/fft_stream_adapter.sv
// Serial-to-parallel front end and parallel-to-serial back end for a DFT core.
//
// state   | meaning
// FILL    | accepting N input samples into the frame buffer
// ISSUE   | core_next pulse, frame loaded onto core_in
// FEED    | core_in valid, timeout counter cleared
// WAIT    | waiting for core_next_out or timeout
// CAPTURE | core_out registered (conjugated/scaled in inverse mode)
// DRAIN   | replaying the result serially with backpressure
module fft_stream_adapter
    import fft_stream_pkg::*;
#(
    parameter int N         = 8,
    parameter int DATA_W    = 16,
    parameter int SCALE_INV = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_re,
    input  logic [DATA_W-1:0]        in_im,
    input  logic                     in_inv,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_re,
    output logic [DATA_W-1:0]        out_im,
    output logic                     out_last,
    output logic                     core_next,
    output logic [2*N*DATA_W-1:0]    core_in,
    input  logic                     core_next_out,
    input  logic [2*N*DATA_W-1:0]    core_out,
    output logic                     busy,
    output logic                     err_timeout
);

    localparam int LOG2N = $clog2(N);
    localparam int CW    = (LOG2N < 1) ? 1 : LOG2N;
    localparam int TW    = $clog2(TIMEOUT + 1);

    state_t                   state;
    logic [CW-1:0]            count;
    logic [TW-1:0]            tcnt;
    logic                     inv_q;
    logic                     conj_in;
    logic                     scale_cap;
    logic signed [DATA_W-1:0] st_re, st_im;
    logic signed [DATA_W-1:0] fbuf_re [N];
    logic signed [DATA_W-1:0] fbuf_im [N];
    logic signed [DATA_W-1:0] obuf_re [N];
    logic signed [DATA_W-1:0] obuf_im [N];
    logic signed [DATA_W-1:0] cap_re  [N];
    logic signed [DATA_W-1:0] cap_im  [N];

    // The first sample of a frame decides the mode before inv_q is loaded.
    assign conj_in   = (count == '0) ? in_inv : inv_q;
    assign scale_cap = inv_q && (SCALE_INV != 0);

    cplx_conj_scale #(.DATA_W(DATA_W), .SHIFT(LOG2N)) u_in (
        .a_re  (in_re),
        .a_im  (in_im),
        .conj  (conj_in),
        .scale (1'b0),
        .y_re  (st_re),
        .y_im  (st_im)
    );

    for (genvar k = 0; k < N; k++) begin : g_cap
        cplx_conj_scale #(.DATA_W(DATA_W), .SHIFT(LOG2N)) u_cap (
            .a_re  (core_out[2*k*DATA_W +: DATA_W]),
            .a_im  (core_out[(2*k+1)*DATA_W +: DATA_W]),
            .conj  (inv_q),
            .scale (scale_cap),
            .y_re  (cap_re[k]),
            .y_im  (cap_im[k])
        );
    end

    // Frame buffers keep their contents across reset.
    always_ff @(posedge clk) begin
        if (state == FILL && in_valid) begin
            fbuf_re[count] <= st_re;
            fbuf_im[count] <= st_im;
        end
        if (state == CAPTURE) begin
            for (int k = 0; k < N; k++) begin
                obuf_re[k] <= cap_re[k];
                obuf_im[k] <= cap_im[k];
            end
        end
    end

    // Sequencer with registered handshake, core and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FILL;
            count       <= '0;
            tcnt        <= '0;
            inv_q       <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_re      <= '0;
            out_im      <= '0;
            out_last    <= 1'b0;
            core_next   <= 1'b0;
            core_in     <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            core_next <= 1'b0;
            case (state)
                FILL: begin
                    if (in_valid && in_ready) begin
                        if (count == '0) inv_q <= in_inv;
                        if (count == CW'(N - 1)) begin
                            count     <= '0;
                            state     <= ISSUE;
                            in_ready  <= 1'b0;
                            core_next <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                ISSUE: begin
                    for (int k = 0; k < N; k++) begin
                        core_in[2*k*DATA_W +: DATA_W]     <= fbuf_re[k];
                        core_in[(2*k+1)*DATA_W +: DATA_W] <= fbuf_im[k];
                    end
                    state <= FEED;
                end
                FEED: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_next_out) begin
                        state <= CAPTURE;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= FILL;
                        in_ready    <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                CAPTURE: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (!out_valid || out_ready) begin
                        if (out_valid && out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            count     <= '0;
                            state     <= FILL;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            out_valid <= 1'b1;
                            out_re    <= obuf_re[count];
                            out_im    <= obuf_im[count];
                            out_last  <= (count == CW'(N - 1));
                            count     <= count + CW'(1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
